rst_seq_sonata: RTL and testbench
=================================

Name: rst_seq_sonata

Overview:
Reset sequencer for the Sonata top level. It replaces the free-running power-on counter and generates the staged resets for the Ibex demo system. Inputs are the raw reset button, the clock generator lock and a software/debug reset request. Outputs are separate peripheral and core resets, the boot-OK LED drive and a reset-cause record. It runs on the buffered board clock, ahead of the system clock generator's own reset synchroniser.

Parameters:
- DebounceCycles, 16: consecutive stable synchronised samples needed before the debounced button state changes; must be >= 2.
- HoldCycles, 195: cycles both resets stay asserted after lock and button release qualify; must be >= 1.
- PeriphLeadCycles, 4: cycles between peripheral reset release and core reset release; must be >= 1.

Ports:
- clk_sys_i, input, 1: sequencer clock.
- rst_sys_ni, input, 1: asynchronous, active-low reset.
- btn_rst_ni, input, 1: raw reset button, asynchronous, low = pressed.
- pll_locked_i, input, 1: clock generator lock, asynchronous.
- sw_rst_req_i, input, 1: single-cycle software/debug reset request, synchronous to clk_sys_i.
- rst_periph_no, output, 1: peripheral/bus reset, active-low.
- rst_core_no, output, 1: core and debug-module reset, active-low.
- boot_ok_o, output, 1: high while in RUN.
- rst_cause_o, output, 2: cause of the last reset. 0 = POR, 1 = lock loss, 2 = button, 3 = software.
- rst_count_o, output, 8: saturating count of non-POR reset events.

Behaviour:
- Reset values (async, rst_sys_ni low):
  - state = WAIT_LOCK.
  - rst_periph_no = 0, rst_core_no = 0, boot_ok_o = 0.
  - rst_cause_o = 0, rst_count_o = 0.
  - Synchroniser flops: button = 1, lock = 0.
  - Debounced button = 1 (released); debounce counter = 0.
- btn_rst_ni and pll_locked_i each pass through a 2-flop synchroniser. lock_s is usable 2 cycles after its input changes.
- Debouncer:
  - Counter clears whenever btn_s equals btn_db.
  - Otherwise it increments.
  - When it reaches DebounceCycles-1, btn_db takes btn_s and the counter clears.
  - Net effect: btn_db changes after DebounceCycles consecutive differing samples; shorter glitches are ignored.
- All outputs are registered; no combinational path from any input to any output.
- State machine:
  - WAIT_LOCK: both resets 0. When lock_s = 1 and btn_db = 1, load hold counter with HoldCycles-1 and go to HOLD.
  - HOLD: both resets 0. Decrement each cycle; at 0, go to PERIPH.
  - PERIPH: rst_periph_no = 1, rst_core_no = 0. Lead counter runs PeriphLeadCycles cycles, then go to RUN.
  - RUN: both resets 1, boot_ok_o = 1.
- Timing: if lock_s rises in cycle t with the button released, the state is HOLD from t+1. rst_periph_no rises at t+1+HoldCycles. rst_core_no and boot_ok_o rise at t+1+HoldCycles+PeriphLeadCycles.
- Reset events are evaluated every cycle in HOLD, PERIPH and RUN, in this priority:
  1. lock_s = 0: go to WAIT_LOCK, cause = 1.
  2. btn_db = 0: go to WAIT_LOCK, cause = 2. WAIT_LOCK is held while btn_db = 0.
  3. sw_rst_req_i = 1, honoured in RUN and PERIPH only: go to HOLD with counter reloaded, cause = 3. The lock wait is skipped.
- In the cycle an event is taken, both resets are driven 0 and boot_ok_o 0, registered on the next edge.
- rst_cause_o is updated on the same edge and held until the next event.
- rst_count_o increments once per event and saturates at 255.
- Events in WAIT_LOCK are not counted and do not change the cause.
- sw_rst_req_i in WAIT_LOCK or HOLD is ignored.
- Reset mid-sequence: asserting rst_sys_ni at any point returns all state to the reset values immediately (async); there is no partial release.

Test Plan:
- POR, button released, pll_locked_i rises at cycle 10 (defaults):
  - rst_periph_no rises at cycle 208 (lock_s at 12, HOLD from 13, 13+195); rst_core_no and boot_ok_o rise at 212.
  - rst_cause_o = 0, rst_count_o = 0.
- In RUN, a 10-cycle button low pulse: no output change. A 40-cycle press: both resets drop about 19 cycles after the press edge, cause = 2, count = 1. Re-release follows the full HOLD and lead sequence after debounce.
- In RUN, pulse sw_rst_req_i for 1 cycle: resets drop next cycle, cause = 3, count +1. rst_periph_no returns after 1+195 cycles and rst_core_no 4 cycles later, with no lock wait.
- Drop pll_locked_i during HOLD at counter = 50: state returns to WAIT_LOCK, cause = 1. The sequence restarts only after lock returns.
- Same cycle: lock_s = 0 and sw_rst_req_i = 1 in RUN: cause = 1, state = WAIT_LOCK, count +1 only once.
- Apply 260 sw requests, each after returning to RUN: rst_count_o saturates at 255. Assert rst_sys_ni low mid-PERIPH: all outputs go to reset values immediately.

Source files
------------

// File: rtl/rst_seq_sonata_if.sv
// Reset sequencer bundle: raw reset sources in, staged resets and cause record out.
// The master side stimulates the sources; the sequencer sits on the slave side.
interface rst_seq_sonata_if;
   logic       btn_rst_ni;
   logic       pll_locked_i;
   logic       sw_rst_req_i;
   logic       rst_periph_no;
   logic       rst_core_no;
   logic       boot_ok_o;
   logic [1:0] rst_cause_o;
   logic [7:0] rst_count_o;

   modport master (
      output btn_rst_ni, pll_locked_i, sw_rst_req_i,
      input  rst_periph_no, rst_core_no, boot_ok_o, rst_cause_o, rst_count_o
   );

   modport slave (
      input  btn_rst_ni, pll_locked_i, sw_rst_req_i,
      output rst_periph_no, rst_core_no, boot_ok_o, rst_cause_o, rst_count_o
   );
endinterface

// File: rtl/rst_seq_sonata.sv
// Staged reset sequencer: waits for lock and a released button, holds both resets,
// releases the peripheral reset first and the core reset a few cycles later.
module rst_seq_sonata #(
   parameter int DebounceCycles   = 16,
   parameter int HoldCycles       = 195,
   parameter int PeriphLeadCycles = 4
) (
   input logic              clk_sys_i,
   input logic              rst_sys_ni,
   rst_seq_sonata_if.slave  bus
);

   localparam int DW = $clog2(DebounceCycles);
   localparam int HW = $clog2(HoldCycles + 1);
   localparam int LW = $clog2(PeriphLeadCycles + 1);

   localparam logic [DW-1:0] DB_LAST   = DW'(DebounceCycles - 1);
   localparam logic [HW-1:0] HOLD_LOAD = HW'(HoldCycles - 1);
   localparam logic [LW-1:0] LEAD_LOAD = LW'(PeriphLeadCycles - 1);

   localparam logic [1:0] CAUSE_LOCK = 2'd1;
   localparam logic [1:0] CAUSE_BTN  = 2'd2;
   localparam logic [1:0] CAUSE_SW   = 2'd3;

   typedef enum logic [1:0] {WAIT_LOCK, HOLD, PERIPH, RUN} state_t;

   state_t          state_reg, state_next;
   logic [HW-1:0]   hold_cnt_reg, hold_cnt_next;
   logic [LW-1:0]   lead_cnt_reg, lead_cnt_next;
   logic [1:0]      cause_reg, cause_next;
   logic [7:0]      count_reg, count_next;
   logic [1:0]      btn_sync_reg, lock_sync_reg;
   logic            btn_db_reg;
   logic [DW-1:0]   db_cnt_reg;
   logic            periph_reg, core_reg, boot_ok_reg;
   logic            btn_s, lock_s;

   assign btn_s  = btn_sync_reg[1];
   assign lock_s = lock_sync_reg[1];

   // Button idles released and lock idles lost, so reset never fakes a qualified start.
   always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
      if (!rst_sys_ni) begin
         btn_sync_reg  <= 2'b11;
         lock_sync_reg <= 2'b00;
         btn_db_reg    <= 1'b1;
         db_cnt_reg    <= '0;
      end else begin
         btn_sync_reg  <= {btn_sync_reg[0], bus.btn_rst_ni};
         lock_sync_reg <= {lock_sync_reg[0], bus.pll_locked_i};
         if (btn_s == btn_db_reg) begin
            db_cnt_reg <= '0;
         end else if (db_cnt_reg == DB_LAST) begin
            btn_db_reg <= btn_s;
            db_cnt_reg <= '0;
         end else begin
            db_cnt_reg <= db_cnt_reg + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
      if (!rst_sys_ni) begin
         state_reg    <= WAIT_LOCK;
         hold_cnt_reg <= '0;
         lead_cnt_reg <= '0;
         cause_reg    <= '0;
         count_reg    <= '0;
         periph_reg   <= 1'b0;
         core_reg     <= 1'b0;
         boot_ok_reg  <= 1'b0;
      end else begin
         state_reg    <= state_next;
         hold_cnt_reg <= hold_cnt_next;
         lead_cnt_reg <= lead_cnt_next;
         cause_reg    <= cause_next;
         count_reg    <= count_next;
         // Decoded from the next state so the resets change on the same edge as the state.
         periph_reg   <= (state_next == PERIPH) || (state_next == RUN);
         core_reg     <= (state_next == RUN);
         boot_ok_reg  <= (state_next == RUN);
      end
   end

   always_comb begin
      state_next    = state_reg;
      hold_cnt_next = hold_cnt_reg;
      lead_cnt_next = lead_cnt_reg;
      cause_next    = cause_reg;
      count_next    = count_reg;

      if (state_reg == WAIT_LOCK) begin
         if (lock_s && btn_db_reg) begin
            state_next    = HOLD;
            hold_cnt_next = HOLD_LOAD;
         end
      end else if (!lock_s || !btn_db_reg ||
                   (bus.sw_rst_req_i && (state_reg != HOLD))) begin
         // One event per cycle, whichever source has priority records the cause.
         if (count_reg != 8'hFF) begin
            count_next = count_reg + 8'd1;
         end
         if (!lock_s) begin
            state_next = WAIT_LOCK;
            cause_next = CAUSE_LOCK;
         end else if (!btn_db_reg) begin
            state_next = WAIT_LOCK;
            cause_next = CAUSE_BTN;
         end else begin
            state_next    = HOLD;
            hold_cnt_next = HOLD_LOAD;
            cause_next    = CAUSE_SW;
         end
      end else begin
         unique case (state_reg)
            HOLD: begin
               if (hold_cnt_reg == '0) begin
                  state_next    = PERIPH;
                  lead_cnt_next = LEAD_LOAD;
               end else begin
                  hold_cnt_next = hold_cnt_reg - 1'b1;
               end
            end
            PERIPH: begin
               if (lead_cnt_reg == '0) begin
                  state_next = RUN;
               end else begin
                  lead_cnt_next = lead_cnt_reg - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.rst_periph_no = periph_reg;
   assign bus.rst_core_no   = core_reg;
   assign bus.boot_ok_o     = boot_ok_reg;
   assign bus.rst_cause_o   = cause_reg;
   assign bus.rst_count_o   = count_reg;

endmodule

// File: tb/tb_rst_seq_sonata.sv
// Directed bench for the reset sequencer; all timings are counted in clock edges
// from the point an input is driven (1 time unit after a rising edge).
module tb_rst_seq_sonata;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   int   exp_count;

   rst_seq_sonata_if bus ();

   rst_seq_sonata dut (
      .clk_sys_i  (clk),
      .rst_sys_ni (rst_n),
      .bus        (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.btn_rst_ni = 1'b1;
      bus.pll_locked_i = 1'b0;
      bus.sw_rst_req_i = 1'b0;
      tick(3);
      checks++; if (bus.rst_periph_no !== 1'b0) begin errors++; $display("FAIL reset_periph got %b exp 0", bus.rst_periph_no); end
      checks++; if (bus.rst_core_no !== 1'b0) begin errors++; $display("FAIL reset_core got %b exp 0", bus.rst_core_no); end
      checks++; if (bus.boot_ok_o !== 1'b0) begin errors++; $display("FAIL reset_boot got %b exp 0", bus.boot_ok_o); end
      checks++; if (bus.rst_cause_o !== 2'd0) begin errors++; $display("FAIL reset_cause got %0d exp 0", bus.rst_cause_o); end
      checks++; if (bus.rst_count_o !== 8'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.rst_count_o); end
      rst_n = 1'b1;
      tick(10);
      exp_count = 0;
      $display("test_reset done");
   endtask

   task automatic test_por_boot();
      bus.pll_locked_i = 1'b1;
      tick(197);
      checks++; if (bus.rst_periph_no !== 1'b0) begin errors++; $display("FAIL por_periph_early got %b exp 0", bus.rst_periph_no); end
      tick(1);
      checks++; if (bus.rst_periph_no !== 1'b1) begin errors++; $display("FAIL por_periph_rise got %b exp 1", bus.rst_periph_no); end
      checks++; if (bus.rst_core_no !== 1'b0) begin errors++; $display("FAIL por_core_lead got %b exp 0", bus.rst_core_no); end
      tick(3);
      checks++; if (bus.rst_core_no !== 1'b0) begin errors++; $display("FAIL por_core_early got %b exp 0", bus.rst_core_no); end
      tick(1);
      checks++; if (bus.rst_core_no !== 1'b1) begin errors++; $display("FAIL por_core_rise got %b exp 1", bus.rst_core_no); end
      checks++; if (bus.boot_ok_o !== 1'b1) begin errors++; $display("FAIL por_boot got %b exp 1", bus.boot_ok_o); end
      checks++; if (bus.rst_cause_o !== 2'd0) begin errors++; $display("FAIL por_cause got %0d exp 0", bus.rst_cause_o); end
      checks++; if (bus.rst_count_o !== 8'd0) begin errors++; $display("FAIL por_count got %0d exp 0", bus.rst_count_o); end
      $display("test_por_boot done");
   endtask

   task automatic test_glitch();
      bus.btn_rst_ni = 1'b0;
      tick(10);
      bus.btn_rst_ni = 1'b1;
      tick(30);
      checks++; if (bus.rst_core_no !== 1'b1) begin errors++; $display("FAIL glitch_core got %b exp 1", bus.rst_core_no); end
      checks++; if (bus.rst_periph_no !== 1'b1) begin errors++; $display("FAIL glitch_periph got %b exp 1", bus.rst_periph_no); end
      checks++; if (bus.rst_count_o !== 8'd0) begin errors++; $display("FAIL glitch_count got %0d exp 0", bus.rst_count_o); end
      $display("test_glitch done");
   endtask

   task automatic test_button_press();
      bus.btn_rst_ni = 1'b0;
      tick(18);
      checks++; if (bus.rst_core_no !== 1'b1) begin errors++; $display("FAIL btn_core_early got %b exp 1", bus.rst_core_no); end
      tick(1);
      exp_count++;
      checks++; if (bus.rst_periph_no !== 1'b0) begin errors++; $display("FAIL btn_periph_drop got %b exp 0", bus.rst_periph_no); end
      checks++; if (bus.boot_ok_o !== 1'b0) begin errors++; $display("FAIL btn_boot_drop got %b exp 0", bus.boot_ok_o); end
      checks++; if (bus.rst_cause_o !== 2'd2) begin errors++; $display("FAIL btn_cause got %0d exp 2", bus.rst_cause_o); end
      checks++; if (bus.rst_count_o !== 8'(exp_count)) begin errors++; $display("FAIL btn_count got %0d exp %0d", bus.rst_count_o, exp_count); end
      tick(21);
      bus.btn_rst_ni = 1'b1;
      tick(213);
      checks++; if (bus.rst_periph_no !== 1'b0) begin errors++; $display("FAIL btn_rel_periph_early got %b exp 0", bus.rst_periph_no); end
      tick(1);
      checks++; if (bus.rst_periph_no !== 1'b1) begin errors++; $display("FAIL btn_rel_periph got %b exp 1", bus.rst_periph_no); end
      tick(4);
      checks++; if (bus.rst_core_no !== 1'b1) begin errors++; $display("FAIL btn_rel_core got %b exp 1", bus.rst_core_no); end
      $display("test_button_press done");
   endtask

   task automatic test_sw_request();
      bus.sw_rst_req_i = 1'b1;
      tick(1);
      bus.sw_rst_req_i = 1'b0;
      exp_count++;
      checks++; if (bus.rst_periph_no !== 1'b0) begin errors++; $display("FAIL sw_periph_drop got %b exp 0", bus.rst_periph_no); end
      checks++; if (bus.rst_cause_o !== 2'd3) begin errors++; $display("FAIL sw_cause got %0d exp 3", bus.rst_cause_o); end
      checks++; if (bus.rst_count_o !== 8'(exp_count)) begin errors++; $display("FAIL sw_count got %0d exp %0d", bus.rst_count_o, exp_count); end
      tick(194);
      checks++; if (bus.rst_periph_no !== 1'b0) begin errors++; $display("FAIL sw_periph_early got %b exp 0", bus.rst_periph_no); end
      tick(1);
      checks++; if (bus.rst_periph_no !== 1'b1) begin errors++; $display("FAIL sw_periph_rise got %b exp 1", bus.rst_periph_no); end
      tick(3);
      checks++; if (bus.rst_core_no !== 1'b0) begin errors++; $display("FAIL sw_core_early got %b exp 0", bus.rst_core_no); end
      tick(1);
      checks++; if (bus.rst_core_no !== 1'b1) begin errors++; $display("FAIL sw_core_rise got %b exp 1", bus.rst_core_no); end
      $display("test_sw_request done");
   endtask

   task automatic test_lock_loss();
      bus.sw_rst_req_i = 1'b1;
      tick(1);
      bus.sw_rst_req_i = 1'b0;
      exp_count++;
      tick(144);
      bus.pll_locked_i = 1'b0;
      tick(2);
      checks++; if (bus.rst_cause_o !== 2'd3) begin errors++; $display("FAIL lock_cause_early got %0d exp 3", bus.rst_cause_o); end
      tick(1);
      exp_count++;
      checks++; if (bus.rst_cause_o !== 2'd1) begin errors++; $display("FAIL lock_cause got %0d exp 1", bus.rst_cause_o); end
      checks++; if (bus.rst_count_o !== 8'(exp_count)) begin errors++; $display("FAIL lock_count got %0d exp %0d", bus.rst_count_o, exp_count); end
      tick(60);
      checks++; if (bus.rst_periph_no !== 1'b0) begin errors++; $display("FAIL lock_wait_periph got %b exp 0", bus.rst_periph_no); end
      bus.pll_locked_i = 1'b1;
      tick(197);
      checks++; if (bus.rst_periph_no !== 1'b0) begin errors++; $display("FAIL lock_ret_periph_early got %b exp 0", bus.rst_periph_no); end
      tick(1);
      checks++; if (bus.rst_periph_no !== 1'b1) begin errors++; $display("FAIL lock_ret_periph got %b exp 1", bus.rst_periph_no); end
      tick(4);
      checks++; if (bus.boot_ok_o !== 1'b1) begin errors++; $display("FAIL lock_ret_boot got %b exp 1", bus.boot_ok_o); end
      $display("test_lock_loss done");
   endtask

   task automatic test_same_cycle();
      bus.pll_locked_i = 1'b0;
      tick(2);
      bus.sw_rst_req_i = 1'b1;
      tick(1);
      bus.sw_rst_req_i = 1'b0;
      exp_count++;
      checks++; if (bus.rst_cause_o !== 2'd1) begin errors++; $display("FAIL same_cause got %0d exp 1", bus.rst_cause_o); end
      checks++; if (bus.rst_count_o !== 8'(exp_count)) begin errors++; $display("FAIL same_count got %0d exp %0d", bus.rst_count_o, exp_count); end
      tick(220);
      checks++; if (bus.rst_periph_no !== 1'b0) begin errors++; $display("FAIL same_wait_lock got %b exp 0", bus.rst_periph_no); end
      bus.pll_locked_i = 1'b1;
      tick(202);
      checks++; if (bus.rst_core_no !== 1'b1) begin errors++; $display("FAIL same_ret_core got %b exp 1", bus.rst_core_no); end
      checks++; if (bus.rst_count_o !== 8'(exp_count)) begin errors++; $display("FAIL same_count_after got %0d exp %0d", bus.rst_count_o, exp_count); end
      $display("test_same_cycle done");
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 260; i++) begin
         bus.sw_rst_req_i = 1'b1;
         tick(1);
         bus.sw_rst_req_i = 1'b0;
         if (exp_count < 255) exp_count++;
         checks++; if (bus.rst_count_o !== 8'(exp_count)) begin errors++; $display("FAIL sat_count req %0d got %0d exp %0d", i, bus.rst_count_o, exp_count); end
         tick(200);
      end
      checks++; if (bus.rst_count_o !== 8'd255) begin errors++; $display("FAIL sat_final got %0d exp 255", bus.rst_count_o); end
      checks++; if (bus.boot_ok_o !== 1'b1) begin errors++; $display("FAIL sat_boot got %b exp 1", bus.boot_ok_o); end
      $display("test_saturation done");
   endtask

   task automatic test_reset_mid_periph();
      bus.sw_rst_req_i = 1'b1;
      tick(1);
      bus.sw_rst_req_i = 1'b0;
      tick(197);
      checks++; if (bus.rst_periph_no !== 1'b1) begin errors++; $display("FAIL mid_periph_pre got %b exp 1", bus.rst_periph_no); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (bus.rst_periph_no !== 1'b0) begin errors++; $display("FAIL mid_periph got %b exp 0", bus.rst_periph_no); end
      checks++; if (bus.rst_core_no !== 1'b0) begin errors++; $display("FAIL mid_core got %b exp 0", bus.rst_core_no); end
      checks++; if (bus.boot_ok_o !== 1'b0) begin errors++; $display("FAIL mid_boot got %b exp 0", bus.boot_ok_o); end
      checks++; if (bus.rst_cause_o !== 2'd0) begin errors++; $display("FAIL mid_cause got %0d exp 0", bus.rst_cause_o); end
      checks++; if (bus.rst_count_o !== 8'd0) begin errors++; $display("FAIL mid_count got %0d exp 0", bus.rst_count_o); end
      tick(2);
      rst_n = 1'b1;
      $display("test_reset_mid_periph done");
   endtask

   initial begin
      checks = 0;
      errors = 0;
      exp_count = 0;
      test_reset();
      test_por_boot();
      test_glitch();
      test_button_press();
      test_sw_request();
      test_lock_loss();
      test_same_cycle();
      test_saturation();
      test_reset_mid_periph();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
